// File: rtl/stage_memory_pkg.sv
// Types shared by the memory-access stage: control bundles from compute, FSM state,
// bus request fields and the lane-offset helpers.
package stage_memory_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic [1:0] REG_WRITE_FROM_COMPUTE = 2'd0;
    localparam logic [1:0] REG_WRITE_FROM_MEMORY  = 2'd1;
    localparam logic [1:0] REG_WRITE_FROM_PC      = 2'd2;

    typedef struct packed {
        logic            w_enable;
        logic [1:0]      width;
        logic            r_sign_extend;
        logic [XLEN-1:0] w_value;
    } compute_mem_control_t;

    typedef struct packed {
        logic       enable;
        logic [4:0] which_register;
        logic [1:0] source;
    } compute_reg_control_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mem_stage_state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
    } mem_bus_req_t;

    // Byte offset with the bits below the access size cleared; unknown widths act as word.
    function automatic logic [1:0] align_offset(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE: return off;
            WIDTH_HALF: return {off[1], 1'b0};
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        return align_offset(width, off) != off;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes and replicated data, and
// load extraction with zero/sign extension.
module mem_lane_align
    import stage_memory_pkg::*;
(
    input  logic [1:0]      width,
    input  logic [1:0]      offset,
    input  logic            sign_extend,
    input  logic [XLEN-1:0] store_value,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_value
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        wstrb      = 4'hF;
        wdata      = store_value;
        shifted    = load_word >> {offset, 3'b000};
        load_value = load_word;
        case (width)
            WIDTH_BYTE: begin
                wstrb      = 4'b0001 << offset;
                wdata      = {4{store_value[7:0]}};
                load_value = {{24{sign_extend & shifted[7]}}, shifted[7:0]};
            end
            WIDTH_HALF: begin
                wstrb      = 4'b0011 << offset;
                wdata      = {2{store_value[15:0]}};
                load_value = {{16{sign_extend & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory-access stage: at most one load/store per instruction over a single-outstanding bus.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module stage_memory
    import stage_memory_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [XLEN-1:0]      compute_result,
    input  compute_mem_control_t control_mem,
    input  compute_reg_control_t control_rd_in,
    output logic                 stall,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [XLEN-1:0]      bus_addr,
    output logic [XLEN-1:0]      bus_wdata,
    output logic [3:0]           bus_wstrb,
    input  logic                 bus_ready,
    input  logic [XLEN-1:0]      bus_rdata,
    output logic [XLEN-1:0]      wb_value,
    output compute_reg_control_t control_rd_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                 misalign_fault,
`endif
    output mem_stage_state_t     debug_state
);

    // Bus handshake: bus_req and all request fields are held constant from the first
    // BUS cycle through the cycle in which bus_ready is sampled high; bus_ready is
    // ignored outside BUS, and a reset simply abandons the request.
    mem_stage_state_t     state, state_next;
    mem_bus_req_t         req_q;
    logic [1:0]           width_q, off_q;
    logic                 sign_q, load_q;
    compute_reg_control_t rd_q;

    logic            is_store, is_load, is_mem, misaligned;
    logic [1:0]      eff_off, lane_width, lane_off;
    logic [3:0]      lane_wstrb;
    logic [XLEN-1:0] lane_wdata, lane_load;

    // A store with rd also set is illegal; the store wins and rd is dropped.
    assign is_store = control_mem.w_enable;
    assign is_load  = !control_mem.w_enable && control_rd_in.enable
                      && (control_rd_in.source == REG_WRITE_FROM_MEMORY);
    assign is_mem   = is_store || is_load;
    assign eff_off  = align_offset(control_mem.width, compute_result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_mem && is_misaligned(control_mem.width, compute_result[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Store lanes are computed from live inputs at acceptance, load lanes from latched fields.
    assign lane_width = (state == BUS) ? width_q : control_mem.width;
    assign lane_off   = (state == BUS) ? off_q : eff_off;

    mem_lane_align u_lane (
        .width       (lane_width),
        .offset      (lane_off),
        .sign_extend (sign_q),
        .store_value (control_mem.w_value),
        .load_word   (bus_rdata),
        .wstrb       (lane_wstrb),
        .wdata       (lane_wdata),
        .load_value  (lane_load)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && is_mem && !misaligned) state_next = BUS;
            BUS:     if (bus_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall       = (state == BUS);
    assign bus_req     = (state == BUS);
    assign bus_we      = req_q.we;
    assign bus_addr    = req_q.addr;
    assign bus_wdata   = req_q.wdata;
    assign bus_wstrb   = req_q.wstrb;
    assign debug_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_q          <= '0;
            width_q        <= 2'b00;
            off_q          <= 2'b00;
            sign_q         <= 1'b0;
            load_q         <= 1'b0;
            rd_q           <= '0;
            wb_value       <= '0;
            control_rd_out <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            state <= state_next;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!enable) begin
                        control_rd_out.enable <= 1'b0;
                    end else if (!is_mem) begin
                        wb_value       <= compute_result;
                        control_rd_out <= control_rd_in;
                    end else begin
                        control_rd_out.enable <= 1'b0;
                        if (misaligned) begin
`ifdef MEM_MISALIGN_TRAP_EN
                            misalign_fault <= 1'b1;
`endif
                        end else begin
                            req_q.we    <= is_store;
                            req_q.addr  <= {compute_result[XLEN-1:2], 2'b00};
                            req_q.wdata <= lane_wdata;
                            req_q.wstrb <= is_store ? lane_wstrb : 4'b0000;
                            width_q     <= control_mem.width;
                            off_q       <= eff_off;
                            sign_q      <= control_mem.r_sign_extend;
                            load_q      <= is_load;
                            rd_q        <= control_rd_in;
                        end
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        if (load_q) begin
                            wb_value       <= lane_load;
                            control_rd_out <= rd_q;
                        end else begin
                            control_rd_out.enable <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboarded bench for stage_memory: directed cases, then random instructions
// against an arithmetic reference model. Honours MEM_MISALIGN_TRAP_EN.
module tb_stage_memory;
    import stage_memory_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic [31:0]          compute_result;
    compute_mem_control_t control_mem;
    compute_reg_control_t control_rd_in;
    logic                 stall, bus_req, bus_we;
    logic [31:0]          bus_addr, bus_wdata;
    logic [3:0]           bus_wstrb;
    logic                 bus_ready;
    logic [31:0]          bus_rdata;
    logic [31:0]          wb_value;
    compute_reg_control_t control_rd_out;
    mem_stage_state_t     debug_state;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 misalign_fault;
`endif

    stage_memory dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .compute_result (compute_result),
        .control_mem    (control_mem),
        .control_rd_in  (control_rd_in),
        .stall          (stall),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_ready      (bus_ready),
        .bus_rdata      (bus_rdata),
        .wb_value       (wb_value),
        .control_rd_out (control_rd_out),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_fault (misalign_fault),
`endif
        .debug_state    (debug_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic                 we;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [3:0]           wstrb;
        logic                 is_load;
        logic [1:0]           width;
        logic [1:0]           off;
        logic                 sign;
        compute_reg_control_t rd;
    } bus_exp_t;

    bus_exp_t    bus_exp_q[$];
    logic [39:0] exp_q[$];
    int          fault_cyc_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;

    int          force_wait = -1;
    bit          force_rdata_en = 0;
    logic [31:0] force_rdata = '0;
    bit          resp_en = 1;
    bit          in_txn = 0;
    bit          have_cur = 0;
    int          wait_left = 0;
    bus_exp_t    cur;
    logic [68:0] held;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event not expected / bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] model_off(input logic [1:0] w, input logic [31:0] a);
        int o;
        o = a % 4;
        if (w == WIDTH_HALF) o = o - (o % 2);
        else if (w != WIDTH_BYTE) o = 0;
        return 2'(o);
    endfunction

    function automatic bit model_misaligned(input logic [1:0] w, input logic [31:0] a);
        if (w == WIDTH_BYTE) return 0;
        if (w == WIDTH_HALF) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [1:0] w, input logic [1:0] off,
                                               input logic sign, input logic [31:0] rdata);
        logic [31:0] sh, x;
        sh = rdata >> (8 * off);
        if (w == WIDTH_BYTE) begin
            x = sh % 256;
            if (sign && x >= 128) x = x + 32'hFFFF_FF00;
        end else if (w == WIDTH_HALF) begin
            x = sh % 65536;
            if (sign && x >= 32768) x = x + 32'hFFFF_0000;
        end else begin
            x = rdata;
        end
        return x;
    endfunction

    task automatic model_issue(input logic [31:0] res, input compute_mem_control_t m,
                               input compute_reg_control_t r);
        bus_exp_t e;
        bit st, ld;
        st = m.w_enable;
        ld = !st && r.enable && (r.source == REG_WRITE_FROM_MEMORY);
        if (st || ld) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (model_misaligned(m.width, res)) begin
                fault_cyc_q.push_back(cyc + 1);
                return;
            end
`endif
            e.we      = st;
            e.off     = model_off(m.width, res);
            e.addr    = res - (res % 4);
            e.is_load = ld;
            e.width   = m.width;
            e.sign    = m.r_sign_extend;
            e.rd      = r;
            if (m.width == WIDTH_BYTE) begin
                e.wdata = m.w_value[7:0] * 32'h0101_0101;
                e.wstrb = 4'(1 << e.off);
            end else if (m.width == WIDTH_HALF) begin
                e.wdata = m.w_value[15:0] * 32'h0001_0001;
                e.wstrb = 4'(3 << e.off);
            end else begin
                e.wdata = m.w_value;
                e.wstrb = 4'hF;
            end
            if (!st) e.wstrb = 4'h0;
            bus_exp_q.push_back(e);
        end else if (r.enable) begin
            exp_q.push_back({r, res});
        end
    endtask

    // ---------------- driver ----------------
    function automatic compute_mem_control_t mk_mem(input logic we, input logic [1:0] w,
                                                    input logic sx, input logic [31:0] v);
        compute_mem_control_t m;
        m.w_enable = we; m.width = w; m.r_sign_extend = sx; m.w_value = v;
        return m;
    endfunction

    function automatic compute_reg_control_t mk_rd(input logic en, input logic [4:0] rg,
                                                   input logic [1:0] src);
        compute_reg_control_t r;
        r.enable = en; r.which_register = rg; r.source = src;
        return r;
    endfunction

    task automatic drive(input logic en, input logic [31:0] res, input compute_mem_control_t m,
                         input compute_reg_control_t r);
        int guard;
        guard = 0;
        @(negedge clk);
        while (stall && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (stall) fail_now("stall_timeout");
        enable         = en;
        compute_result = res;
        control_mem    = m;
        control_rd_in  = r;
        if (en) model_issue(res, m, r);
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, '0, '0);
    endtask

    task automatic issue_random();
        compute_mem_control_t m;
        compute_reg_control_t r;
        logic [31:0] res;
        int kind;
        kind = $urandom_range(0, 9);
        res  = $urandom;
        m = mk_mem(1'b0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
        r = mk_rd(1'b1, 5'($urandom_range(0, 31)), REG_WRITE_FROM_COMPUTE);
        case (kind)
            0, 1: drive(1'b0, res, m, r);
            2, 3: begin
                r.source = $urandom_range(0, 1) ? REG_WRITE_FROM_PC : REG_WRITE_FROM_COMPUTE;
                r.enable = ($urandom_range(0, 4) != 0);
                drive(1'b1, res, m, r);
            end
            4: begin
                r.source = REG_WRITE_FROM_MEMORY;
                r.enable = 1'b0;
                drive(1'b1, res, m, r);
            end
            5, 6, 7: begin
                r.source = REG_WRITE_FROM_MEMORY;
                drive(1'b1, res, m, r);
            end
            default: begin
                m.w_enable = 1'b1;
                r.enable   = 1'($urandom_range(0, 1));
                r.source   = 2'($urandom_range(0, 2));
                drive(1'b1, res, m, r);
            end
        endcase
    endtask

    // ---------------- bus responder ----------------
    initial begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) continue;
            bus_ready = 1'b0;
            if (!reset_n) begin
                in_txn = 0;
            end else if (bus_req) begin
                if (!in_txn) begin
                    in_txn    = 1;
                    wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
                    held      = {bus_we, bus_addr, bus_wdata, bus_wstrb};
                    if (bus_exp_q.size() == 0) begin
                        have_cur = 0;
                        fail_now("unexpected_bus_req");
                    end else begin
                        have_cur = 1;
                        cur = bus_exp_q.pop_front();
                        check("bus_we", bus_we, cur.we);
                        check("bus_addr", bus_addr, cur.addr);
                        check("bus_wstrb", bus_wstrb, cur.wstrb);
                        if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                    end
                end else begin
                    check("bus_hold", {bus_we, bus_addr, bus_wdata, bus_wstrb}, held);
                end
                if (wait_left == 0) begin
                    bus_ready = 1'b1;
                    bus_rdata = force_rdata_en ? force_rdata : $urandom;
                    if (have_cur && cur.is_load)
                        exp_q.push_back({cur.rd, load_model(cur.width, cur.off, cur.sign, bus_rdata)});
                    in_txn = 0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- writeback / fault monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (reset_n && control_rd_out.enable) begin
                if (exp_q.size() == 0) fail_now("unexpected_wb");
                else check("wb", {control_rd_out, wb_value}, exp_q.pop_front());
            end
`ifdef MEM_MISALIGN_TRAP_EN
            begin
                bit exp_f;
                exp_f = (fault_cyc_q.size() > 0) && (fault_cyc_q[0] == cyc);
                if (exp_f) void'(fault_cyc_q.pop_front());
                check("misalign_fault", misalign_fault, exp_f);
            end
`endif
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        reset_n        = 1'b0;
        enable         = 1'b0;
        compute_result = '0;
        control_mem    = '0;
        control_rd_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_wstrb", bus_wstrb, 0);
        check("rst_stall", stall, 0);
        check("rst_wb_value", wb_value, 0);
        check("rst_rd_enable", control_rd_out.enable, 0);
        check("rst_state", debug_state, IDLE);
        reset_n = 1'b1;

        // ALU pass-through
        s0 = stall_cnt;
        drive(1'b1, 32'h1234, '0, mk_rd(1'b1, 5'd5, REG_WRITE_FROM_COMPUTE));
        drive_idle();
        drive_idle();
        check("alu_stall", stall_cnt - s0, 0);
        check("alu_wb_value", wb_value, 32'h1234);

        // Signed byte load, three BUS cycles
        force_wait = 2; force_rdata_en = 1; force_rdata = 32'h80FF_0000;
        s0 = stall_cnt;
        drive(1'b1, 32'h1003, mk_mem(1'b0, WIDTH_BYTE, 1'b1, 32'h0), mk_rd(1'b1, 5'd9, REG_WRITE_FROM_MEMORY));
        drive_idle();
        check("lb_stall_cycles", stall_cnt - s0, 3);
        check("lb_wb_value", wb_value, 32'hFFFF_FF80);
        force_wait = -1;

        // Half store, then unsigned half load
        drive(1'b1, 32'h2002, mk_mem(1'b1, WIDTH_HALF, 1'b0, 32'h0000_ABCD), mk_rd(1'b0, 5'd0, REG_WRITE_FROM_COMPUTE));
        drive_idle();
        force_rdata = 32'h0000_8001;
        drive(1'b1, 32'h0, mk_mem(1'b0, WIDTH_HALF, 1'b0, 32'h0), mk_rd(1'b1, 5'd3, REG_WRITE_FROM_MEMORY));
        drive_idle();
        check("lhu_wb_value", wb_value, 32'h0000_8001);

        // Misaligned word load
        force_rdata = 32'hCAFE_F00D;
        drive(1'b1, 32'h3001, mk_mem(1'b0, WIDTH_WORD, 1'b0, 32'h0), mk_rd(1'b1, 5'd4, REG_WRITE_FROM_MEMORY));
        drive_idle();
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw_mis_no_req", bus_req, 0);
`else
        check("lw_mis_wb_value", wb_value, 32'hCAFE_F00D);
`endif
        force_rdata_en = 0;

        // Reset in the middle of a transaction
        force_wait = 1000;
        drive(1'b1, 32'h40, mk_mem(1'b0, WIDTH_WORD, 1'b0, 32'h0), mk_rd(1'b1, 5'd7, REG_WRITE_FROM_MEMORY));
        @(negedge clk);
        @(negedge clk);
        check("rstbus_req_active", bus_req, 1);
        resp_en = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        @(posedge clk);
        #1;
        check("rstbus_req_drop", bus_req, 0);
        check("rstbus_stall", stall, 0);
        check("rstbus_state", debug_state, IDLE);
        @(negedge clk);
        in_txn    = 0;
        reset_n   = 1'b1;
        bus_ready = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rstbus_no_wb", control_rd_out.enable, 0);
            check("rstbus_no_req", bus_req, 0);
        end
        force_wait = -1;
        resp_en    = 1;

        // Random traffic
        repeat (400) issue_random();
        repeat (6) drive_idle();
        check("wb_queue_drained", exp_q.size(), 0);
        check("bus_queue_drained", bus_exp_q.size(), 0);
        check("fault_queue_drained", fault_cyc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        fail_now("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
# stage_memory

Pipeline memory-access stage sitting directly downstream of the compute stage. Consumes the compute result (effective address or ALU value), the `compute_mem_control_t` bundle and the `compute_reg_control_t` bundle, performs at most one load or store per instruction over a single-outstanding ready/valid data bus, and hands a writeback value plus register control to the writeback stage. Stalls the upstream pipeline while a bus transaction is in flight.

## Interface
- `XLEN`, 32, data/address width (from `isa_constants.sv`)
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `enable`  in  1  upstream slot holds a valid instruction
- `compute_result`  in  XLEN  address for memory ops; pass-through value otherwise
- `control_mem`  in  compute_mem_control_t  w_enable, width, r_sign_extend, w_value
- `control_rd_in`  in  compute_reg_control_t  enable, which_register, source
- `stall`  out  1  upstream must hold its outputs this cycle
- `bus_req`  out  1  transaction request
- `bus_we`  out  1  1 = store
- `bus_addr`  out  XLEN  word-aligned address (bits [1:0] = 0)
- `bus_wdata`  out  XLEN  store data, replicated into lanes
- `bus_wstrb`  out  4  byte-lane strobes
- `bus_ready`  in  1  transaction complete this cycle
- `bus_rdata`  in  XLEN  load data, valid with `bus_ready`
- `wb_value`  out  XLEN  writeback value
- `control_rd_out`  out  compute_reg_control_t  writeback register control
- `misalign_fault`  out  1  present only with `MEM_MISALIGN_TRAP_EN`

## Operation
- Load: `control_rd_in.enable` and `source == REG_WRITE_FROM_MEMORY`. Store: `control_mem.w_enable`. Both set at once is illegal; store wins and rd write is suppressed.
- FSM states: IDLE, BUS.
  - IDLE, `enable` low: `control_rd_out.enable` <= 0.
  - IDLE, `enable` high, non-memory instruction: register `wb_value <= compute_result` and `control_rd_out <= control_rd_in`. Stay in IDLE.
  - IDLE, `enable` high, load or store: latch the address, width, sign-extend flag, write data and rd control. Go to BUS. `control_rd_out.enable` <= 0.
  - BUS: `bus_req` = 1, `stall` = 1. On `bus_ready`, go to IDLE. A load registers the extracted value into `wb_value` and asserts the latched `control_rd_out`. A store leaves `control_rd_out.enable` = 0.
- Lane rules. `off` = addr[1:0].
  - Byte: `wstrb = 1<<off`; `wdata` = byte replicated ×4; load data = `rdata[8*off+:8]`.
  - Half: `wstrb = 3<<off` (off ∈ {0,2}); `wdata` = half replicated ×2; load data = `rdata[8*off+:16]`.
  - Word: `wstrb = 4'hF`.
  - Loads zero-extend, or sign-extend when `r_sign_extend` is set. `bus_wstrb` = 0 when `bus_we` = 0.
- Bus outputs are stable for as long as `bus_req` is held. Only one transaction is outstanding at a time.

## Timing
- Reset values: state IDLE, `bus_req` 0, `bus_we` 0, `bus_addr`/`bus_wdata`/`bus_wstrb` 0, `stall` 0, `wb_value` 0, `control_rd_out.enable` 0, `misalign_fault` 0.
- `stall` is combinational: 1 iff state == BUS.
- Non-memory instruction: 1-cycle latency to `wb_value`/`control_rd_out`.
- Memory instruction accepted at edge N:
  - `bus_req` is high from cycle N+1.
  - If `bus_ready` arrives in cycle N+k (k ≥ 1), the result is valid after edge N+k+1.
  - The next instruction is accepted at edge N+k+1.
- `bus_ready` while in IDLE is ignored.
- Reset asserted mid-transaction: the FSM returns to IDLE at that edge and `bus_req` drops. Any later `bus_ready`/`bus_rdata` is ignored; the bus must tolerate an abandoned request.
- `enable` is not sampled while in BUS.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, issues no bus request.
  - The FSM stays in IDLE, `misalign_fault` pulses for 1 cycle after acceptance, and `control_rd_out.enable` = 0.
- Undefined:
  - No fault port.
  - The low address bits are forced aligned: half clears addr[0], word clears addr[1:0].

## Structure
- Shared package (`isa_types.sv`): new `mem_stage_state_t` enum (IDLE, BUS) and a `mem_bus_req_t` struct (we, addr, wdata, wstrb). `compute_mem_control_t`, `compute_reg_control_t`, `WIDTH_*` and `REG_WRITE_FROM_*` are reused unchanged.
- One sub-module, `mem_lane_align`: purely combinational; computes wstrb, replicated wdata and load extraction/extension from width, offset and sign flag.

## Test plan
- ALU pass-through: `enable`=1, result 0x1234, rd x5 from COMPUTE → next cycle `wb_value` 0x1234, rd enable, `stall` never high.
- Signed byte load at 0x1003, `bus_ready` after 3 BUS cycles with rdata 0x80FF_0000 → `bus_addr` 0x1000, `stall` high 3 cycles, `wb_value` 0xFFFF_FF80.
- Half store of 0xABCD at 0x2002 → `bus_we`=1, `wstrb` 4'b1100, `wdata` 0xABCD_ABCD, no rd write.
- Unsigned half load at 0x0 with rdata 0x0000_8001 → `wb_value` 0x0000_8001.
- Reset during BUS → next cycle `bus_req` 0, state IDLE; a following `bus_ready` pulse causes no writeback.
- Word load at 0x3001: with `MEM_MISALIGN_TRAP_EN` → `misalign_fault` 1 for 1 cycle, no `bus_req`; without it → `bus_addr` 0x3000, normal load.
